// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path and the downstream
// command detector.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 434;

   localparam logic [7:0] ASCII_S = 8'h53;
   localparam logic [7:0] ASCII_T = 8'h54;
   localparam logic [7:0] ASCII_A = 8'h41;
   localparam logic [7:0] ASCII_R = 8'h52;

   // True for any character that can appear in the START command word.
   function automatic logic is_cmd_char(input logic [7:0] c);
      logic hit_s;
      case (c)
         ASCII_S, ASCII_T, ASCII_A, ASCII_R: hit_s = 1'b1;
         default:                            hit_s = 1'b0;
      endcase
      return hit_s;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous input; resets to 1 so an
// idle-high line reads idle straight out of reset.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_r;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= {STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 LSB-first UART receiver: rx is synchronised, the start bit is checked
// at its centre, and every later bit is sampled one bit period apart.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       rx_complete,
   output logic       frame_error,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

   logic              rxs_s;
   uart_state_t       state_r, state_s;
   logic [CNT_W-1:0]  clk_cnt_r, clk_cnt_s;
   logic [2:0]        bit_idx_r, bit_idx_s;
   logic [7:0]        shift_r, shift_s;
   logic [7:0]        data_out_r, data_out_s;
   logic              rx_complete_r, rx_complete_s;
   logic              frame_error_r, frame_error_s;
   logic              busy_r;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rxs_s)
   );

   // Next-state, datapath and output-pulse decode.
   always_comb begin
      state_s       = state_r;
      clk_cnt_s     = clk_cnt_r;
      bit_idx_s     = bit_idx_r;
      shift_s       = shift_r;
      data_out_s    = data_out_r;
      rx_complete_s = 1'b0;
      frame_error_s = 1'b0;

      case (state_r)
         IDLE: begin
            if (!rxs_s) begin
               clk_cnt_s = ZERO_CNT;
               state_s   = START;
            end else begin
               state_s   = IDLE;
            end
         end

         // A start bit that is no longer low at its centre is a glitch.
         START: begin
            if (clk_cnt_r == HALF_CNT) begin
               if (!rxs_s) begin
                  clk_cnt_s = ZERO_CNT;
                  bit_idx_s = 3'd0;
                  state_s   = DATA;
               end else begin
                  state_s   = IDLE;
               end
            end else begin
               clk_cnt_s = clk_cnt_r + ONE_CNT;
            end
         end

         DATA: begin
            if (clk_cnt_r == LAST_CNT) begin
               shift_s[bit_idx_r] = rxs_s;
               clk_cnt_s          = ZERO_CNT;
               if (bit_idx_r == 3'd7) begin
                  state_s   = STOP;
               end else begin
                  bit_idx_s = bit_idx_r + 3'd1;
               end
            end else begin
               clk_cnt_s = clk_cnt_r + ONE_CNT;
            end
         end

         STOP: begin
            if (clk_cnt_r == LAST_CNT) begin
               clk_cnt_s = ZERO_CNT;
               if (rxs_s) begin
                  data_out_s    = shift_r;
                  rx_complete_s = 1'b1;
                  state_s       = IDLE;
               end else begin
                  frame_error_s = 1'b1;
                  state_s       = WAIT_HIGH;
               end
            end else begin
               clk_cnt_s = clk_cnt_r + ONE_CNT;
            end
         end

         // Hold off while the line is in a break so it cannot re-trigger.
         WAIT_HIGH: begin
            if (rxs_s) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT_HIGH;
            end
         end

         default: begin
            state_s   = IDLE;
            clk_cnt_s = ZERO_CNT;
            bit_idx_s = 3'd0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         clk_cnt_r     <= ZERO_CNT;
         bit_idx_r     <= 3'd0;
         shift_r       <= 8'h00;
         data_out_r    <= 8'h00;
         rx_complete_r <= 1'b0;
         frame_error_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         clk_cnt_r     <= clk_cnt_s;
         bit_idx_r     <= bit_idx_s;
         shift_r       <= shift_s;
         data_out_r    <= data_out_s;
         rx_complete_r <= rx_complete_s;
         frame_error_r <= frame_error_s;
         busy_r        <= (state_s != IDLE);
      end
   end

   assign data_out    = data_out_r;
   assign rx_complete = rx_complete_r;
   assign frame_error = frame_error_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at 16 clocks per bit.
module tb_uart_rx_byte;

   localparam int CPB = 16;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] data_out;
   logic       rx_complete;
   logic       frame_error;
   logic       busy;

   logic [7:0] exp_q[$];
   int         n_tests;
   int         n_fail;
   int         done_cnt;
   int         ferr_cycles;
   int         unexp_cnt;
   int         both_cnt;
   logic       busy_seen;
   logic [7:0] exp_byte;

   uart_rx_byte #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .data_out    (data_out),
      .rx_complete (rx_complete),
      .frame_error (frame_error),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (busy) busy_seen = 1'b1;
      if (frame_error) ferr_cycles++;
      if (rx_complete && frame_error) both_cnt++;
      if (rx_complete) begin
         done_cnt++;
         if (exp_q.size() > 0) begin
            exp_byte = exp_q.pop_front();
            check("rx_data", 32'(data_out), 32'(exp_byte));
            check("busy_at_done", 32'(busy), 32'd0);
         end else begin
            unexp_cnt++;
         end
      end
   end

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      if (stop_bit) exp_q.push_back(b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_bit);
   endtask

   task automatic settle_and_check(input string tag, input int exp_done);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
   endtask

   initial begin
      logic [7:0] start_word [5];
      int ferr_before;
      start_word[0] = 8'h53; start_word[1] = 8'h54; start_word[2] = 8'h41;
      start_word[3] = 8'h52; start_word[4] = 8'h54;
      n_tests = 0; n_fail = 0; done_cnt = 0; ferr_cycles = 0;
      unexp_cnt = 0; both_cnt = 0; busy_seen = 1'b0;
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(data_out), 32'h00);
      check("rst_done", 32'(rx_complete), 32'd0);
      check("rst_ferr", 32'(frame_error), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Single 'S'.
      send_frame(8'h53, 1'b1);
      settle_and_check("single", 1);
      check("single_ferr", 32'(ferr_cycles), 32'd0);

      // "START" with no idle gap.
      foreach (start_word[i]) send_frame(start_word[i], 1'b1);
      settle_and_check("start_word", 6);
      check("start_word_ferr", 32'(ferr_cycles), 32'd0);
      check("start_word_last", 32'(data_out), 32'h54);

      // Short low glitch on the line.
      busy_seen = 1'b0;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_busy_seen", 32'(busy_seen), 32'd1);
      check("glitch_idle", 32'(busy), 32'd0);
      check("glitch_done", 32'(done_cnt), 32'd6);
      check("glitch_ferr", 32'(ferr_cycles), 32'd0);

      // Bad stop bit followed by a held break.
      ferr_before = ferr_cycles;
      send_frame(8'hA5, 1'b0);
      repeat (48) @(negedge clk);
      check("break_busy", 32'(busy), 32'd1);
      check("break_ferr", 32'(ferr_cycles - ferr_before), 32'd1);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("break_release_busy", 32'(busy), 32'd0);
      check("break_data_held", 32'(data_out), 32'h54);
      check("break_done", 32'(done_cnt), 32'd6);
      check("break_ferr_total", 32'(ferr_cycles - ferr_before), 32'd1);

      // Reset in the middle of bit 4 of 0xFF.
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (4 * CPB + CPB / 2) @(negedge clk);
      check("pre_reset_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("midrst_data", 32'(data_out), 32'h00);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(rx_complete), 32'd0);
      check("midrst_ferr", 32'(frame_error), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5 * CPB) @(negedge clk);
      check("post_reset_done", 32'(done_cnt), 32'd6);
      send_frame(8'h0F, 1'b1);
      settle_and_check("after_reset", 7);
      check("after_reset_data", 32'(data_out), 32'h0F);

      // Extreme patterns.
      send_frame(8'h00, 1'b1);
      settle_and_check("zero", 8);
      check("zero_data", 32'(data_out), 32'h00);
      send_frame(8'hFF, 1'b1);
      settle_and_check("ones", 9);
      check("ones_data", 32'(data_out), 32'hFF);

      check("unexpected_done", 32'(unexp_cnt), 32'd0);
      check("done_and_ferr", 32'(both_cnt), 32'd0);
      check("ferr_total", 32'(ferr_cycles), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
